// File: rtl/cdc_rx_frame_assembler.sv
// cdc_rx_frame_assembler: packs WORDS captured words into frames and queues them in a DEPTH-entry FIFO.
// Define FRAME_PARITY_EN to treat the last word as an XOR check word and drop failing frames.
module cdc_rx_frame_assembler #(
  parameter int WIDTH = 7,
  parameter int WORDS = 4,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       capture,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       abort,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [WIDTH*WORDS-1:0]     frame_data,
  output logic [$clog2(WORDS)-1:0]   word_idx,
  output logic                       overflow,
  output logic [7:0]                 drop_count,
  input  logic                       clear_overflow,
  output logic                       parity_err
);
  localparam int IW = $clog2(WORDS);
  localparam int AW = $clog2(DEPTH);
  typedef logic [IW-1:0] idx_t;
  typedef logic [AW:0] ptr_t;
  typedef enum logic {EMPTY, FILL} state_t;
  state_t state_q, state_d;
  idx_t idx_q, idx_d;
  logic [WORDS-1:0][WIDTH-1:0] slot_q, frame_w;
  logic [DEPTH-1:0][WIDTH*WORDS-1:0] mem;
  ptr_t wp, rp;
  logic take, last, parity_ok, push_req, full, empty, pop, push, drop;
  // The frame being completed is the stored slots with the incoming word merged into the current slot.
  always_comb begin
    frame_w = slot_q;
    frame_w[idx_q] = data_in;
  end
  assign take = capture && !abort;
  assign last = state_q == FILL && idx_q == idx_t'(WORDS-1);
  always_comb begin
    idx_d = abort ? '0 : !capture ? idx_q : last ? '0 : idx_q + idx_t'(1);
    state_d = idx_d == '0 ? EMPTY : FILL;
  end
`ifdef FRAME_PARITY_EN
  logic [WIDTH-1:0] chk;
  always_comb begin
    chk = '0;
    for (int i = 0; i < WORDS-1; i++) chk ^= frame_w[i];
  end
  assign parity_ok = chk == frame_w[WORDS-1];
  always_ff @(posedge clk or posedge reset)
    if (reset) parity_err <= 1'b0;
    else parity_err <= take && last && !parity_ok;
`else
  assign parity_ok = 1'b1;
  assign parity_err = 1'b0;
`endif
  assign empty = wp == rp;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign pop = !empty && frame_ready;
  assign push_req = take && last && parity_ok;
  // A same-cycle pop frees the head slot, so a full FIFO can still accept the push.
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= EMPTY;
      idx_q <= '0;
      slot_q <= '0;
      mem <= '0;
      wp <= '0;
      rp <= '0;
      overflow <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      if (take) slot_q <= frame_w;
      if (push) begin
        mem[wp[AW-1:0]] <= frame_w;
        wp <= wp + ptr_t'(1);
      end
      if (pop) rp <= rp + ptr_t'(1);
      if (drop) begin
        overflow <= 1'b1;
        drop_count <= clear_overflow ? 8'd1 : drop_count + 8'(drop_count != 8'hff);
      end else if (clear_overflow) begin
        overflow <= 1'b0;
        drop_count <= 8'd0;
      end
    end
  assign frame_valid = !empty;
  assign frame_data = mem[rp[AW-1:0]];
  assign word_idx = idx_q;
endmodule

// File: tb/tb_cdc_rx_frame_assembler.sv
// tb_cdc_rx_frame_assembler: scoreboard bench; a queue-based model predicts frames, drops and flags.
module tb_cdc_rx_frame_assembler;
  localparam int W = 7, WORDS = 4, DEPTH = 2, FW = W * WORDS;
  logic clk = 1'b0;
  logic reset, capture, abort, frame_ready, clear_overflow;
  logic [W-1:0] data_in;
  logic frame_valid, overflow, parity_err;
  logic [FW-1:0] frame_data;
  logic [1:0] word_idx;
  logic [7:0] drop_count;
  int checks = 0, failures = 0;
  bit go = 1'b0;
  logic [W-1:0] part[$], n_part[$];
  logic [FW-1:0] exp_q[$], pend_frame;
  bit ovf, n_ovf, perr, n_perr, push_pend;
  int dcnt, n_dcnt;

  cdc_rx_frame_assembler #(.WIDTH(W), .WORDS(WORDS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .capture(capture), .data_in(data_in), .abort(abort),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
    .word_idx(word_idx), .overflow(overflow), .drop_count(drop_count),
    .clear_overflow(clear_overflow), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pxor();
    logic [W-1:0] x = '0;
    foreach (part[i]) x ^= part[i];
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    part = n_part;
    ovf = n_ovf;
    dcnt = n_dcnt;
    perr = n_perr;
    if (push_pend) exp_q.push_back(pend_frame);
    push_pend = 1'b0;
    #1;
  endtask

  task automatic drive(input bit cap, input logic [W-1:0] d, input bit ab, rdy, clr, rs);
    bit pop, ok, dropped;
    logic [FW-1:0] f;
    logic [W-1:0] x;
    capture = cap; data_in = d; abort = ab; frame_ready = rdy; clear_overflow = clr; reset = rs;
    n_part = part; n_ovf = ovf; n_dcnt = dcnt; n_perr = 1'b0; push_pend = 1'b0; dropped = 1'b0;
    if (rs) begin
      part.delete(); exp_q.delete(); n_part.delete();
      ovf = 1'b0; dcnt = 0; perr = 1'b0; n_ovf = 1'b0; n_dcnt = 0;
    end else begin
      pop = exp_q.size() > 0 && rdy;
      if (ab) n_part.delete();
      else if (cap) begin
        n_part.push_back(d);
        if (n_part.size() == WORDS) begin
          f = '0; x = '0;
          for (int i = 0; i < WORDS; i++) f[i*W +: W] = n_part[i];
          for (int i = 0; i < WORDS - 1; i++) x ^= n_part[i];
          ok = 1'b1;
`ifdef FRAME_PARITY_EN
          ok = x == n_part[WORDS-1];
`endif
          if (!ok) n_perr = 1'b1;
          else if (exp_q.size() == DEPTH && !pop) begin
            dropped = 1'b1;
            n_ovf = 1'b1;
            n_dcnt = clr ? 1 : (dcnt < 255 ? dcnt + 1 : 255);
          end else begin
            push_pend = 1'b1;
            pend_frame = f;
          end
          n_part.delete();
        end
      end
      if (clr && !dropped) begin n_ovf = 1'b0; n_dcnt = 0; end
    end
  endtask

  task automatic step(input bit cap, input logic [W-1:0] d, input bit ab, rdy, clr, rs);
    tick();
    drive(cap, d, ab, rdy, clr, rs);
  endtask

  task automatic send(input logic [W-1:0] a, b, c, d, input bit rdy, rdy_last, clr_last);
`ifdef FRAME_PARITY_EN
    d = a ^ b ^ c;
`endif
    step(1, a, 0, rdy, 0, 0);
    step(1, b, 0, rdy, 0, 0);
    step(1, c, 0, rdy, 0, 0);
    step(1, d, 0, rdy_last, clr_last, 0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, rdy, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares every DUT output against the model and retires frames on handshakes.
  initial begin
    wait (go);
    forever begin
      @(negedge clk);
      chk("valid", frame_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) chk("data", frame_data, exp_q[0]);
      chk("word_idx", word_idx, part.size());
      chk("overflow", overflow, ovf);
      chk("drop_count", drop_count, dcnt);
      chk("parity_err", parity_err, perr);
      if (frame_valid && frame_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b1; capture = 1'b0; data_in = '0; abort = 1'b0; frame_ready = 1'b0; clear_overflow = 1'b0;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    go = 1'b1;
    @(negedge clk);
    chk("rst_valid", frame_valid, 0);
    chk("rst_data", frame_data, 0);
    chk("rst_idx", word_idx, 0);
    chk("rst_drop", drop_count, 0);
    step(0, 0, 0, 1, 0, 0);
    send(7'h11, 7'h22, 7'h33, 7'h44, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("tp1_valid", frame_valid, 1);
`ifdef FRAME_PARITY_EN
    chk("tp1_data", frame_data, 32'h00CD111);
`else
    chk("tp1_data", frame_data, 32'h88CD111);
`endif
    chk("tp1_idx", word_idx, 0);
    step(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("tp1_one_cycle", frame_valid, 0);
    do_reset();
    send(7'h01, 7'h02, 7'h03, 7'h04, 0, 0, 0);
    send(7'h05, 7'h06, 7'h07, 7'h08, 0, 0, 0);
    send(7'h09, 7'h0A, 7'h0B, 7'h0C, 0, 0, 0);
    idle(3, 0);
    @(negedge clk);
    chk("tp2_overflow", overflow, 1);
    chk("tp2_drops", drop_count, 1);
    idle(4, 1);
    do_reset();
    send(7'h21, 7'h22, 7'h23, 7'h24, 0, 0, 0);
    send(7'h31, 7'h32, 7'h33, 7'h34, 0, 0, 0);
    send(7'h41, 7'h42, 7'h43, 7'h44, 0, 1, 0);
    idle(2, 0);
    @(negedge clk);
    chk("tp3_overflow", overflow, 0);
    chk("tp3_valid", frame_valid, 1);
    idle(4, 1);
    do_reset();
    step(1, 7'h11, 0, 1, 0, 0);
    step(1, 7'h22, 0, 1, 0, 0);
    step(1, 7'h33, 1, 1, 0, 0);
    send(7'h01, 7'h02, 7'h03, 7'h04, 1, 1, 0);
    idle(3, 1);
    do_reset();
    for (int i = 0; i < 7; i++) send(W'(i), W'(i + 1), W'(i + 2), W'(i + 3), 0, 0, 0);
    @(negedge clk);
    send(7'h55, 7'h56, 7'h57, 7'h58, 0, 0, 1);
    idle(1, 0);
    @(negedge clk);
    chk("tp5_clr_overflow", overflow, 1);
    chk("tp5_clr_drops", drop_count, 1);
    for (int i = 0; i < 260; i++) send(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 0, 0, 0);
    idle(1, 0);
    @(negedge clk);
    chk("tp5_saturate", drop_count, 255);
    idle(4, 1);
`ifdef FRAME_PARITY_EN
    do_reset();
    step(1, 7'h11, 0, 0, 0, 0); step(1, 7'h22, 0, 0, 0, 0);
    step(1, 7'h33, 0, 0, 0, 0); step(1, 7'h00, 0, 0, 0, 0);
    step(1, 7'h11, 0, 0, 0, 0); step(1, 7'h22, 0, 0, 0, 0);
    step(1, 7'h33, 0, 0, 0, 0); step(1, 7'h01, 0, 0, 0, 0);
    idle(1, 0);
    @(negedge clk);
    chk("par_err_pulse", parity_err, 1);
    chk("par_overflow", overflow, 0);
    idle(1, 0);
    @(negedge clk);
    chk("par_err_end", parity_err, 0);
    idle(3, 1);
`endif
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] d;
      tick();
      d = W'($urandom);
`ifdef FRAME_PARITY_EN
      if (part.size() == WORDS - 1 && $urandom_range(3) != 0) d = pxor();
`endif
      drive($urandom_range(2) != 0, d, $urandom_range(19) == 0, $urandom_range(1) == 1,
            $urandom_range(29) == 0, $urandom_range(499) == 0);
    end
    idle(6, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
